sub_word_store_ctrl: RTL and testbench



---
 rtl/sub_word_store_ctrl_if.sv | 28 ++
 rtl/sub_word_store_ctrl.sv | 134 +++++++++++++
 tb/tb_sub_word_store_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sub_word_store_ctrl_if.sv
// Store-request and data-memory port bundle for the sub-word store sequencer.
// The slave modport is the sequencer; the master modport is the pipeline/memory side.
interface sub_word_store_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata, mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, err
  );

  modport master (
    output req_valid, req_addr, req_size, req_wdata, mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, err
  );
endinterface

// File: rtl/sub_word_store_ctrl.sv
// Read-modify-write sequencer for sb/sh/sw into a word-only data memory.
// Sub-word stores read the target word, merge the new lane(s), and write it back.
module sub_word_store_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] lane,
  input  logic [7:0] word_b,
  input  logic [7:0] half_b,
  input  logic [7:0] byte_b,
  input  logic [7:0] old_b,
  output logic [7:0] merged_b
);
  logic       hit;
  logic [7:0] new_b;

  always_comb begin
    hit   = 1'b0;
    new_b = byte_b;
    case (size)
      2'b00:   hit = (lane == 2'(LANE));
      2'b01: begin
        hit   = (lane[1] == 1'(LANE / 2));
        new_b = half_b;
      end
      2'b10: begin
        hit   = 1'b1;
        new_b = word_b;
      end
      default: hit = 1'b0;
    endcase
  end

  assign merged_b = hit ? new_b : old_b;
endmodule

module sub_word_store_ctrl #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  sub_word_store_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [3:0][7:0]   old_q;
  logic [3:0][7:0]   merged;
  logic [1:0]        cnt_q;
  logic              err_q;
  logic              accept;
  logic              legal;

  always_comb begin
    legal = 1'b0;
    case (bus.req_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~bus.req_addr[0];
      2'b10:   legal = (bus.req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && legal) nxt = (bus.req_size == 2'b10) ? WRITE : READ;
      READ:    nxt = WAIT;
      WAIT:    if (cnt_q == LAST) nxt = WRITE;
      WRITE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waddr_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= accept && !legal;
      if (accept) begin
        waddr_q <= bus.req_addr[ADDR_W+1:2];
        lane_q  <= bus.req_addr[1:0];
        size_q  <= bus.req_size;
        wdata_q <= bus.req_wdata;
      end
      if (state == READ) cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + 2'd1;
      // Read data is only valid on the final WAIT cycle.
      if (state == WAIT && cnt_q == LAST) old_q <= bus.mem_rdata;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sub_word_store_lane #(.LANE(i)) u_lane (
      .size     (size_q),
      .lane     (lane_q),
      .word_b   (wdata_q[8*i +: 8]),
      .half_b   (wdata_q[8*(i%2) +: 8]),
      .byte_b   (wdata_q[7:0]),
      .old_b    (old_q[i]),
      .merged_b (merged[i])
    );
  end

  if (ADDR_W < 30) begin : g_hi_addr
    logic unused_hi_addr;
    assign unused_hi_addr = ^bus.req_addr[31:ADDR_W+2];
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_en    = (state == READ) || (state == WRITE);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = (state == WRITE) ? merged : 32'h0;
  assign bus.done      = (state == WRITE);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sub_word_store_ctrl.sv
// Directed bench: RD_LAT=1 instance (a) and RD_LAT=3 instance (b), each with a word memory model.
module tb_sub_word_store_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub_word_store_ctrl_if #(.ADDR_W(10)) ba ();
  sub_word_store_ctrl_if #(.ADDR_W(10)) bb ();

  sub_word_store_ctrl #(.ADDR_W(10), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  sub_word_store_ctrl #(.ADDR_W(10), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  // Memory models: unread cycles return junk so a mistimed capture shows up.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] rd_a;
  logic [31:0] pb [3];
  logic        pre_en = 1'b0;
  logic        pre_sel = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem_a[pre_addr] <= pre_data;
    else if (ba.mem_en && ba.mem_we) mem_a[ba.mem_addr[3:0]] <= ba.mem_wdata;
    if (pre_en && pre_sel) mem_b[pre_addr] <= pre_data;
    else if (bb.mem_en && bb.mem_we) mem_b[bb.mem_addr[3:0]] <= bb.mem_wdata;
    rd_a  <= (ba.mem_en && !ba.mem_we) ? mem_a[ba.mem_addr[3:0]] : 32'h5A5A5A5A;
    pb[0] <= (bb.mem_en && !bb.mem_we) ? mem_b[bb.mem_addr[3:0]] : 32'h5A5A5A5A;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ba.mem_rdata = rd_a;
  assign bb.mem_rdata = pb[2];

  typedef struct packed {
    logic        ready, en, we, done, err;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } obs_t;

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic [31:0] old;
    logic [31:0] exp;
    int          lat;
    bit          err;
    string       nm;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (!sel) o = '{ba.req_ready, ba.mem_en, ba.mem_we, ba.done, ba.err, ba.mem_addr, ba.mem_wdata};
    else      o = '{bb.req_ready, bb.mem_en, bb.mem_we, bb.done, bb.err, bb.mem_addr, bb.mem_wdata};
    return o;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    if (!sel) begin
      ba.req_valid = v; ba.req_addr = a; ba.req_size = s; ba.req_wdata = d;
    end else begin
      bb.req_valid = v; bb.req_addr = a; bb.req_size = s; bb.req_wdata = d;
    end
  endtask

  task automatic preload(input bit sel, input logic [3:0] wa, input logic [31:0] d);
    pre_sel = sel; pre_addr = wa; pre_data = d; pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the cycle the block is ready again.
  task automatic do_store(input vec_t v);
    obs_t        o;
    int          wk;
    logic [31:0] ww;
    logic [9:0]  wa;
    bit          saw_en;
    o = sample(v.sel);
    chk({v.nm, " ready at accept"}, 64'(o.ready), 64'd1);
    drive(v.sel, 1'b1, v.addr, v.size, v.data);
    @(posedge clk);
    #1 drive(v.sel, 1'b0, ~v.addr, ~v.size, 32'hFFFFFFFF);
    wk = 0; ww = '0; wa = '0; saw_en = 1'b0;
    if (v.err) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        o = sample(v.sel);
        saw_en |= o.en;
        if (k == 1) chk({v.nm, " err/ready t+1"}, 64'({o.err, o.ready}), 64'b11);
        if (k == 2) chk({v.nm, " err t+2"}, 64'(o.err), 64'd0);
      end
      chk({v.nm, " no mem_en"}, 64'(saw_en), 64'd0);
    end else begin
      for (int k = 1; k <= 12 && wk == 0; k++) begin
        @(negedge clk);
        o = sample(v.sel);
        if (k == 1 && v.lat > 1)
          chk({v.nm, " read cycle en/we/addr/wdata"}, 64'({o.en, o.we, o.addr, o.wdata}),
              64'({2'b10, v.addr[11:2], 32'h0}));
        if (o.en && o.we) begin
          wk = k; ww = o.wdata; wa = o.addr;
          chk({v.nm, " done with write"}, 64'(o.done), 64'd1);
        end
      end
      chk({v.nm, " write latency"}, 64'(wk), 64'(v.lat));
      chk({v.nm, " write data"}, 64'(ww), 64'(v.exp));
      chk({v.nm, " write addr"}, 64'(wa), 64'(v.addr[11:2]));
      @(negedge clk);
      o = sample(v.sel);
      chk({v.nm, " ready/en/done after write"}, 64'({o.ready, o.en, o.done}), 64'b100);
    end
  endtask

  vec_t tv [14];
  obs_t ob;
  bit   bad;

  initial begin
    tv[0]  = '{0, 32'h8, 2'b10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 0, "sw a8"};
    tv[1]  = '{0, 32'h6, 2'b01, 32'h0000ABCD, 32'h11223344, 32'hABCD3344, 3, 0, "sh a6"};
    tv[2]  = '{0, 32'h4, 2'b01, 32'h0000ABCD, 32'h11223344, 32'h1122ABCD, 3, 0, "sh a4"};
    tv[3]  = '{0, 32'h0, 2'b00, 32'h000000EE, 32'h11223344, 32'h112233EE, 3, 0, "sb l0"};
    tv[4]  = '{0, 32'h1, 2'b00, 32'h000000EE, 32'h11223344, 32'h1122EE44, 3, 0, "sb l1"};
    tv[5]  = '{0, 32'h2, 2'b00, 32'h000000EE, 32'h11223344, 32'h11EE3344, 3, 0, "sb l2"};
    tv[6]  = '{0, 32'h3, 2'b00, 32'h000000EE, 32'h11223344, 32'hEE223344, 3, 0, "sb l3"};
    tv[7]  = '{1, 32'h0, 2'b00, 32'h000000EE, 32'h11223344, 32'h112233EE, 5, 0, "lat3 sb l0"};
    tv[8]  = '{1, 32'h1, 2'b00, 32'h000000EE, 32'h11223344, 32'h1122EE44, 5, 0, "lat3 sb l1"};
    tv[9]  = '{1, 32'h2, 2'b00, 32'h000000EE, 32'h11223344, 32'h11EE3344, 5, 0, "lat3 sb l2"};
    tv[10] = '{1, 32'h3, 2'b00, 32'h000000EE, 32'h11223344, 32'hEE223344, 5, 0, "lat3 sb l3"};
    tv[11] = '{0, 32'h5, 2'b01, 32'h00001234, 32'h0,        32'h0,        0, 1, "ill sh a5"};
    tv[12] = '{0, 32'h2, 2'b10, 32'h12345678, 32'h0,        32'h0,        0, 1, "ill sw a2"};
    tv[13] = '{0, 32'h0, 2'b11, 32'h12345678, 32'h0,        32'h0,        0, 1, "ill size3"};

    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    #3;
    chk("reset a outputs", 64'(sample(0)), 64'({5'b10000, 10'h0, 32'h0}));
    chk("reset b outputs", 64'(sample(1)), 64'({5'b10000, 10'h0, 32'h0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      if (!tv[i].err) preload(tv[i].sel, tv[i].addr[5:2], tv[i].old);
      do_store(tv[i]);
    end

    // Same word back to back: second read must see the first write.
    preload(0, 4'd5, 32'h0);
    do_store('{0, 32'h14, 2'b00, 32'h000000AA, 32'h0, 32'h000000AA, 3, 0, "b2b first"});
    do_store('{0, 32'h15, 2'b00, 32'h000000BB, 32'h0, 32'h0000BBAA, 3, 0, "b2b second"});
    chk("b2b final word", 64'(mem_a[5]), 64'h0000BBAA);

    // Reset asserted during WAIT on the long-latency instance.
    preload(1, 4'd3, 32'h11223344);
    drive(1, 1'b1, 32'hC, 2'b00, 32'h77);
    @(posedge clk);
    #1 drive(1, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    ob = sample(1);
    chk("mid-wait en before reset", 64'(ob.en), 64'd0);
    rst_n = 1'b0;
    #1;
    ob = sample(1);
    chk("reset in wait: ready/en/we/done", 64'({ob.ready, ob.en, ob.we, ob.done}), 64'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ob = sample(1);
      bad |= ob.en | ob.done | ~ob.ready;
    end
    chk("no write after reset", 64'(bad), 64'd0);
    chk("word kept after reset", 64'(mem_b[3]), 64'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
